// File: rtl/sid_sched.sv
// sid_sched: time-multiplexes N_SIDS SID cores over one voice and one filter pipeline and mixes them to stereo.
// Define SID_SCHED_MIX_SAT_EN to clamp the mix to 24 bits instead of wrapping.
module sid_sched #(
    parameter int N_SIDS = 2,
    parameter int VOICE_LAT = 1,
    localparam int NV = 3 * N_SIDS,
    localparam int IW = $clog2(NV),
    localparam int SW = (N_SIDS > 1) ? $clog2(N_SIDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  voice_req,
    output logic [IW-1:0]         voice_idx,
    input  logic [23:0]           voice_o,
    input  logic [7:0]            osc_o,
    output logic [8*N_SIDS-1:0]   osc3,
    output logic                  filt_start,
    output logic [SW-1:0]         filt_sid,
    output logic [71:0]           filt_voices,
    input  logic                  filt_done,
    input  logic [23:0]           filt_o,
    input  logic [2*N_SIDS-1:0]   pan,
    output logic [23:0]           audio_left,
    output logic [23:0]           audio_right,
    output logic                  audio_valid,
    output logic                  busy,
    output logic                  overrun
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
    state_e                state_q;
    logic                  voice_req_q;
    logic [IW-1:0]         voice_idx_q;
    logic [VOICE_LAT-1:0]  pv_q;
    logic [IW-1:0]         pidx_q [VOICE_LAT];
    logic [23:0]           voices_q [NV];
    logic [8*N_SIDS-1:0]   osc3_q;
    logic [N_SIDS-1:0]     ready_q;
    logic                  out_q;
    logic                  filt_start_q;
    logic [SW-1:0]         filt_sid_q;
    logic [71:0]           filt_voices_q;
    logic [1:0]            pan_q;
    logic signed [26:0]    acc_l_q, acc_r_q, acc_l_d, acc_r_d, filt_ext;
    logic [23:0]           audio_l_q, audio_r_q, audio_l_d, audio_r_d;
    logic                  audio_valid_q;
    logic                  overrun_q;
    logic                  cap_v;
    logic [IW-1:0]         cap_idx;
    logic [SW-1:0]         nxt_sid;
    logic [71:0]           nxt_voices;
    logic [1:0]            nxt_pan;

`ifdef SID_SCHED_MIX_SAT_EN
    function automatic logic [23:0] sat(input logic signed [26:0] a);
        return (a > 27'sd8388607) ? 24'h7fffff : (a < -27'sd8388608) ? 24'h800000 : a[23:0];
    endfunction
`endif

    always_comb begin
        cap_v = pv_q[VOICE_LAT-1];
        cap_idx = pidx_q[VOICE_LAT-1];
        filt_ext = {{3{filt_o[23]}}, filt_o};
        acc_l_d = acc_l_q + (pan_q[0] ? filt_ext : 27'sd0);
        acc_r_d = acc_r_q + (pan_q[1] ? filt_ext : 27'sd0);
`ifdef SID_SCHED_MIX_SAT_EN
        audio_l_d = sat(acc_l_d);
        audio_r_d = sat(acc_r_d);
`else
        audio_l_d = acc_l_d[23:0];
        audio_r_d = acc_r_d[23:0];
`endif
        nxt_sid = '0;
        nxt_voices = '0;
        nxt_pan = '0;
        // Descending scan leaves the lowest ready SID selected
        for (int k = N_SIDS - 1; k >= 0; k--)
            if (ready_q[k]) nxt_sid = SW'(k);
        for (int k = 0; k < N_SIDS; k++)
            if (nxt_sid == SW'(k)) begin
                nxt_voices = {voices_q[3*k+2], voices_q[3*k+1], voices_q[3*k]};
                nxt_pan = pan[2*k+:2];
            end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            voice_req_q <= 1'b0;
            voice_idx_q <= '0;
            pv_q <= '0;
            osc3_q <= '0;
            ready_q <= '0;
            out_q <= 1'b0;
            filt_start_q <= 1'b0;
            filt_sid_q <= '0;
            filt_voices_q <= '0;
            pan_q <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            audio_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            filt_start_q <= 1'b0;
            audio_valid_q <= 1'b0;
            for (int i = VOICE_LAT - 1; i > 0; i--) begin
                pv_q[i] <= pv_q[i-1];
                pidx_q[i] <= pidx_q[i-1];
            end
            pv_q[0] <= voice_req_q;
            pidx_q[0] <= voice_idx_q;
            for (int c = 0; c < NV; c++)
                if (cap_v && cap_idx == IW'(c)) voices_q[c] <= voice_o;
            if (start && state_q != IDLE) overrun_q <= 1'b1;
            if (!out_q && |ready_q) begin
                filt_start_q <= 1'b1;
                out_q <= 1'b1;
                filt_sid_q <= nxt_sid;
                filt_voices_q <= nxt_voices;
                pan_q <= nxt_pan;
                for (int k = 0; k < N_SIDS; k++)
                    if (nxt_sid == SW'(k)) ready_q[k] <= 1'b0;
            end
            // Third voice of a SID carries OSC3 and completes its filter input set
            for (int k = 0; k < N_SIDS; k++)
                if (cap_v && cap_idx == IW'(3*k+2)) begin
                    osc3_q[8*k+:8] <= osc_o;
                    ready_q[k] <= 1'b1;
                end
            if (filt_done && out_q) begin
                out_q <= 1'b0;
                acc_l_q <= acc_l_d;
                acc_r_q <= acc_r_d;
                if (filt_sid_q == SW'(N_SIDS - 1)) begin
                    audio_l_q <= audio_l_d;
                    audio_r_q <= audio_r_d;
                    audio_valid_q <= 1'b1;
                    state_q <= IDLE;
                end
            end
            if (state_q == IDLE && start) begin
                state_q <= ISSUE;
                voice_req_q <= 1'b1;
                voice_idx_q <= '0;
                acc_l_q <= '0;
                acc_r_q <= '0;
            end else if (state_q == ISSUE) begin
                if (voice_idx_q == IW'(NV - 1)) begin
                    voice_req_q <= 1'b0;
                    state_q <= DRAIN;
                end else begin
                    voice_idx_q <= voice_idx_q + 1'b1;
                end
            end
        end
    end

    assign voice_req = voice_req_q;
    assign voice_idx = voice_idx_q;
    assign osc3 = osc3_q;
    assign filt_start = filt_start_q;
    assign filt_sid = filt_sid_q;
    assign filt_voices = filt_voices_q;
    assign audio_left = audio_l_q;
    assign audio_right = audio_r_q;
    assign audio_valid = audio_valid_q;
    assign busy = state_q != IDLE;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_sid_sched.sv
// tb_sid_sched: directed vector bench for sid_sched with bench-side voice and filter pipeline responders.
module tb_sid_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, filt_done;
    logic        voice_req;
    logic [2:0]  voice_idx;
    logic [23:0] voice_o;
    logic [7:0]  osc_o;
    logic [15:0] osc3;
    logic        filt_start;
    logic [0:0]  filt_sid;
    logic [71:0] filt_voices;
    logic [23:0] filt_o;
    logic [3:0]  pan;
    logic [23:0] audio_left, audio_right;
    logic        audio_valid, busy, overrun;

    logic        start4, voice_req4, filt_start4, filt_done4, audio_valid4, busy4, overrun4;
    logic [3:0]  voice_idx4;
    logic [23:0] voice_o4, filt_o4, audio_left4, audio_right4;
    logic [7:0]  osc_o4, pan4;
    logic [31:0] osc3_4;
    logic [1:0]  filt_sid4;
    logic [71:0] filt_voices4;

    sid_sched #(.N_SIDS(2), .VOICE_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .voice_req(voice_req), .voice_idx(voice_idx),
        .voice_o(voice_o), .osc_o(osc_o), .osc3(osc3), .filt_start(filt_start), .filt_sid(filt_sid),
        .filt_voices(filt_voices), .filt_done(filt_done), .filt_o(filt_o), .pan(pan),
        .audio_left(audio_left), .audio_right(audio_right), .audio_valid(audio_valid),
        .busy(busy), .overrun(overrun));

    sid_sched #(.N_SIDS(4), .VOICE_LAT(3)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .voice_req(voice_req4), .voice_idx(voice_idx4),
        .voice_o(voice_o4), .osc_o(osc_o4), .osc3(osc3_4), .filt_start(filt_start4), .filt_sid(filt_sid4),
        .filt_voices(filt_voices4), .filt_done(filt_done4), .filt_o(filt_o4), .pan(pan4),
        .audio_left(audio_left4), .audio_right(audio_right4), .audio_valid(audio_valid4),
        .busy(busy4), .overrun(overrun4));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk72(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [23:0] vpat(input int i);
        return 24'(40960 + i * 273);
    endfunction

    function automatic logic [7:0] opat(input int i);
        return 8'(16 + i);
    endfunction

    // Voice pipeline models: result for the request issued VOICE_LAT cycles earlier
    int h1 = 0;
    int h4 [3] = '{0, 0, 0};
    always @(negedge clk) begin
        h1 = int'(voice_idx);
        h4[2] = h4[1];
        h4[1] = h4[0];
        h4[0] = int'(voice_idx4);
    end
    always @(posedge clk) begin
        #2;
        voice_o = vpat(h1);
        osc_o = opat(h1);
        voice_o4 = vpat(h4[2]);
        osc_o4 = opat(h4[2]);
    end

    // Filter pipeline model: answers each filt_start after flat cycles
    int flat = 1;
    bit chk_stable = 1'b1;
    logic [23:0] res [2];
    int rs;
    logic [71:0] rv;
    initial begin
        filt_done = 1'b0;
        filt_o = '0;
        forever begin
            @(negedge clk);
            if (filt_start === 1'b1) begin
                rs = int'(filt_sid);
                rv = filt_voices;
                repeat (flat) @(negedge clk);
                if (chk_stable) begin
                    chk("filt_sid_stable", int'(filt_sid), rs);
                    chk72("filt_voices_stable", filt_voices, rv);
                end
                filt_done = 1'b1;
                filt_o = res[rs];
                @(negedge clk);
                filt_done = 1'b0;
            end
        end
    end

    int n_req, idx_bad, n_av, av_cyc, aud_l, aud_r, busy1, busy_av;
    int fs_cyc [2];
    logic [71:0] fv [2];

    task automatic run_frame(input int extra);
        n_req = 0; idx_bad = 0; n_av = 0; av_cyc = -1; busy1 = -1; busy_av = -1;
        fs_cyc = '{-1, -1};
        fv = '{'0, '0};
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start = (c == extra);
            if (c == 1) busy1 = int'(busy);
            if (voice_req) begin
                if (int'(voice_idx) != n_req) idx_bad++;
                n_req++;
            end
            if (filt_start) begin
                fs_cyc[filt_sid] = c;
                fv[filt_sid] = filt_voices;
            end
            if (audio_valid) begin
                n_av++;
                if (av_cyc < 0) begin
                    av_cyc = c;
                    aud_l = int'($signed(audio_left));
                    aud_r = int'($signed(audio_right));
                    busy_av = int'(busy);
                end
            end
            if (av_cyc > 0 && c >= av_cyc + 3) break;
        end
    endtask

    typedef struct {
        logic [3:0] pan;
        int f0, f1, extra, l, r, ov;
    } vec_t;
    vec_t vt [6];

    int n4, bad4, fs4, seen;
    logic [71:0] fv4;

    initial begin
        vt[0] = '{4'b1101, 100, -30, 0, 70, -30, 0};
        vt[1] = '{4'b0000, 5, 7, 0, 0, 0, 0};
        vt[2] = '{4'b1010, 1000, -3000, 0, 0, -2000, 0};
`ifdef SID_SCHED_MIX_SAT_EN
        vt[3] = '{4'b0101, 8000000, 8000000, 0, 8388607, 0, 0};
        vt[4] = '{4'b0101, -8000000, -8000000, 0, -8388608, 0, 0};
`else
        vt[3] = '{4'b0101, 8000000, 8000000, 0, -777216, 0, 0};
        vt[4] = '{4'b0101, -8000000, -8000000, 0, 777216, 0, 0};
`endif
        vt[5] = '{4'b1111, 1, 2, 3, 3, 3, 1};

        rst = 1'b1; start = 1'b0; start4 = 1'b0; pan = '0; pan4 = '0;
        filt_done4 = 1'b0; filt_o4 = '0; res[0] = '0; res[1] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_voice_req", int'(voice_req), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_osc3", int'(osc3), 0);
        chk("rst_audio_left", int'(audio_left), 0);
        chk("rst_filt_start", int'(filt_start), 0);

        for (int v = 0; v < 6; v++) begin
            pan = vt[v].pan;
            res[0] = 24'(vt[v].f0);
            res[1] = 24'(vt[v].f1);
            run_frame(vt[v].extra);
            chk("n_req", n_req, 6);
            chk("idx_seq", idx_bad, 0);
            chk("busy_issue", busy1, 1);
            chk("fs0_cycle", fs_cyc[0], 6);
            chk("fs1_cycle", fs_cyc[1], 9);
            chk72("voices_sid0", fv[0], {vpat(2), vpat(1), vpat(0)});
            chk72("voices_sid1", fv[1], {vpat(5), vpat(4), vpat(3)});
            chk("av_cycle", av_cyc, 11);
            chk("av_pulses", n_av, 1);
            chk("busy_at_av", busy_av, 0);
            chk("audio_left", aud_l, vt[v].l);
            chk("audio_right", aud_r, vt[v].r);
            chk("overrun", int'(overrun), vt[v].ov);
            chk("osc3", int'(osc3), 32'h1512);
        end

        // Reset in DRAIN with a filter job outstanding, late result must be dropped
        pan = 4'b1101; res[0] = 24'd100; res[1] = -24'sd30;
        flat = 20; chk_stable = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_overrun", int'(overrun), 0);
        chk("post_rst_voice_req", int'(voice_req), 0);
        chk("post_rst_filt_start", int'(filt_start), 0);
        chk("post_rst_audio_valid", int'(audio_valid), 0);
        chk("post_rst_audio_left", int'(audio_left), 0);
        chk("post_rst_audio_right", int'(audio_right), 0);
        chk("post_rst_osc3", int'(osc3), 0);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (audio_valid || busy) seen++;
        end
        chk("late_done_ignored", seen, 0);
        flat = 1; chk_stable = 1'b1;
        run_frame(0);
        chk("clean_av_cycle", av_cyc, 11);
        chk("clean_left", aud_l, 70);
        chk("clean_right", aud_r, -30);
        chk("clean_av_pulses", n_av, 1);

        // Start coincident with audio_valid is accepted as a new frame
        run_frame(11);
        chk("b2b_overrun", int'(overrun), 0);
        chk("b2b_req_count", n_req, 9);
        chk("b2b_left", aud_l, 70);
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(posedge clk); #1;
            if (audio_valid) seen = int'($signed(audio_left));
        end
        chk("b2b_second_left", seen, 70);

        // Four SIDs with a three-cycle voice pipeline
        start4 = 1'b1; n4 = 0; bad4 = 0; fs4 = -1; fv4 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start4 = 1'b0;
            if (voice_req4) begin
                if (int'(voice_idx4) != n4) bad4++;
                n4++;
            end
            if (filt_start4 && fs4 < 0) begin
                fs4 = c;
                fv4 = filt_voices4;
            end
        end
        chk("n4_req", n4, 12);
        chk("n4_idx_seq", bad4, 0);
        chk("n4_osc3", int'(osc3_4), 32'h1b181512);
        chk("n4_fs_cycle", fs4, 8);
        chk72("n4_voices_sid0", fv4, {vpat(2), vpat(1), vpat(0)});
        chk("n4_busy", int'(busy4), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sid_sched.md
SID_SCHED -- requirements
Module: sid_sched

Interface
REQ-001 SHALL have parameter N_SIDS, default 2, number of SID cores sharing one voice pipeline and one filter pipeline (legal 1..4).
REQ-002 SHALL have parameter VOICE_LAT, default 1, cycles from voice_req to valid voice_o/osc_o.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse per SID cycle (PHI1->PHI2 phase).
REQ-006 SHALL have port voice_req  output  1  voice pipeline input valid.
REQ-007 SHALL have port voice_idx  output  $clog2(3*N_SIDS)  voice selected: SID = idx/3, voice = idx%3.
REQ-008 SHALL have port voice_o  input  24  voice pipeline result.
REQ-009 SHALL have port osc_o  input  8  oscillator output, aligned with voice_o.
REQ-010 SHALL have port osc3  output  8*N_SIDS  latched OSC3 per SID.
REQ-011 SHALL have port filt_start  output  1  filter pipeline start pulse.
REQ-012 SHALL have port filt_sid  output  $clog2(N_SIDS) (min 1)  SID being filtered.
REQ-013 SHALL have port filt_voices  output  72  {voice3,voice2,voice1} for filt_sid.
REQ-014 SHALL have port filt_done  input  1  filter result valid pulse.
REQ-015 SHALL have port filt_o  input  24  signed filter result.
REQ-016 SHALL have port pan  input  2*N_SIDS  per-SID routing: 00 off, 01 left, 10 right, 11 both.
REQ-017 SHALL have ports audio_left, audio_right  output  24  signed stereo mix; audio_valid  output  1  pulse on update.
REQ-018 SHALL have ports busy  output  1  frame in progress; overrun  output  1  sticky error flag.

Function
REQ-019 States SHALL be IDLE, ISSUE, DRAIN; start in IDLE SHALL enter ISSUE next cycle.
REQ-020 In ISSUE, voice_req SHALL be 1 for exactly 3*N_SIDS consecutive cycles, voice_idx counting 0..3*N_SIDS-1, then state DRAIN.
REQ-021 voice_o SHALL be captured VOICE_LAT cycles after each voice_req into slot voice_idx; osc_o SHALL update osc3[sid] for voice%3 == 2 only.
REQ-022 SID k SHALL become filter-ready the cycle after its third voice is captured; ready SIDs SHALL be served in ascending k order.
REQ-023 filt_start SHALL pulse only when no filter job is outstanding (between filt_start and filt_done); filt_sid/filt_voices SHALL stay stable from filt_start until filt_done.
REQ-024 On filt_done, filt_o SHALL be added to the left accumulator if pan[2k]=1 and to the right if pan[2k+1]=1, with pan sampled at filt_start.
REQ-025 Accumulators SHALL be 27-bit signed, cleared on frame start.
REQ-026 After filt_done for SID N_SIDS-1, audio_left/right SHALL update and audio_valid pulse in the next cycle, state IDLE.
REQ-027 busy SHALL be 1 in ISSUE and DRAIN.
REQ-028 start while busy SHALL be ignored and SHALL set overrun until rst.
REQ-029 filt_done with no outstanding job SHALL be ignored.
REQ-030 start coincident with the audio_valid cycle SHALL be accepted (IDLE reached same edge).

Reset
REQ-031 rst SHALL, at the next clk edge and regardless of state, force IDLE, clear busy, overrun, voice_req, filt_start, audio_valid, accumulators, audio_left/right, osc3 and pending-filter flags to 0.
REQ-032 Outstanding filter results arriving after rst SHALL be dropped per REQ-029.

Configuration
REQ-033 Macro SID_SCHED_MIX_SAT_EN defined: audio_left/right SHALL be the accumulator clamped to [-8388608, 8388607].
REQ-034 Macro undefined: audio_left/right SHALL be accumulator bits [23:0] (two's-complement wrap), no clamp logic.

Verification
REQ-035 N_SIDS=2, VOICE_LAT=1, start pulse -> voice_req 6 cycles, idx 0..5; filt_start for SID0 one cycle after idx2 capture, SID1 after filt_done of SID0.
REQ-036 pan=4'b1101, filt_o SID0=100, SID1=-30 -> audio_left=70, audio_right=-30, single audio_valid pulse.
REQ-037 Second start 3 cycles after first -> ignored, overrun=1, frame completes normally.
REQ-038 SAT_EN, pan=4'b0101, both filt_o=8000000 -> audio_left=8388607; without macro -> 16000000 mod 2^24 = -777216.
REQ-039 rst asserted mid-DRAIN with filter outstanding -> next cycle busy=0, outputs 0; late filt_done ignored; subsequent start runs clean frame.
REQ-040 N_SIDS=4, VOICE_LAT=3 -> 12 voice_req, osc3 lanes hold osc_o of voices 2,5,8,11.
